// File: rtl/iob_axil2iob_pkg.sv
// Shared definitions for the AXI-Lite to IOb bridge.
//   state_t    : bridge FSM encoding (3 bits; unused codes fall back to IDLE)
//   RESP_OKAY  : the only AXI response this bridge ever returns
//   GRANT_WR/RD: encoding of the last_grant register used by the
//                round-robin arbiter (IOB_AXIL2IOB_RR_ARB_EN builds only)
package iob_axil2iob_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RD_RESP = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/iob_axil2iob_slot.sv
// One-entry holding register used for the AW, W and AR channels.
// Ports:
//   clk_i, cke_i, arst_n_i : clock, clock enable, async active-low reset
//   load_i                 : capture data_i and mark the slot full
//   clear_i                : mark the slot empty (wins over load_i)
//   data_i / data_o        : payload in / held payload out
//   full_o                 : slot currently holds a payload
module iob_axil2iob_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clear has priority; the top never loads and clears the same slot in one
  // cycle because a slot is only cleared while full (and thus not ready).
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (cke_i) begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/iob_axil2iob.sv
// AXI-Lite subordinate to IOb manager bridge.
// Buffers AW, W and AR in one-entry slots, arbitrates between a complete
// write (AW+W) and a read, runs one IOb transaction at a time and returns
// the matching B or R response with OKAY status.
// Ports:
//   clk_i, cke_i, arst_n_i : clock, clock enable, async active-low reset
//   axil_aw*/w*/b*         : AXI-Lite write address, data, response channels
//   axil_ar*/r*            : AXI-Lite read address and data channels
//   iob_*                  : IOb manager port towards the peripheral
// Configuration:
//   IOB_AXIL2IOB_RR_ARB_EN : when defined, read/write ties in IDLE are broken
//                            round-robin; otherwise writes always win.
module iob_axil2iob
  import iob_axil2iob_pkg::*;
#(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     arst_n_i,
  input  logic [AXIL_ADDR_W-1:0]   axil_awaddr_i,
  input  logic                     axil_awvalid_i,
  output logic                     axil_awready_o,
  input  logic [AXIL_DATA_W-1:0]   axil_wdata_i,
  input  logic [AXIL_DATA_W/8-1:0] axil_wstrb_i,
  input  logic                     axil_wvalid_i,
  output logic                     axil_wready_o,
  output logic [1:0]               axil_bresp_o,
  output logic                     axil_bvalid_o,
  input  logic                     axil_bready_i,
  input  logic [AXIL_ADDR_W-1:0]   axil_araddr_i,
  input  logic                     axil_arvalid_i,
  output logic                     axil_arready_o,
  output logic [AXIL_DATA_W-1:0]   axil_rdata_o,
  output logic [1:0]               axil_rresp_o,
  output logic                     axil_rvalid_o,
  input  logic                     axil_rready_i,
  output logic                     iob_valid_o,
  output logic [ADDR_W-1:0]        iob_addr_o,
  output logic [DATA_W-1:0]        iob_wdata_o,
  output logic [DATA_W/8-1:0]      iob_wstrb_o,
  input  logic                     iob_ready_i,
  input  logic                     iob_rvalid_i,
  input  logic [DATA_W-1:0]        iob_rdata_i,
  output logic                     iob_rready_o
);

  localparam int WSLOT_W = AXIL_DATA_W + AXIL_DATA_W/8;

  state_t state_q, state_d;
  logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;

  logic aw_full, w_full, ar_full;
  logic aw_clr, w_clr, ar_clr;
  logic aw_hs, w_hs, ar_hs;
  logic [ADDR_W-1:0]  aw_addr, ar_addr;
  logic [WSLOT_W-1:0] w_slot;

  logic write_pend, read_pend, wr_wins_tie;
  logic grant_wr, grant_rd;

  assign aw_hs = axil_awvalid_i & ~aw_full;
  assign w_hs  = axil_wvalid_i & ~w_full;
  assign ar_hs = axil_arvalid_i & ~ar_full;

  iob_axil2iob_slot #(.DATA_W(ADDR_W)) u_aw_slot (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .arst_n_i(arst_n_i),
    .load_i  (aw_hs),
    .clear_i (aw_clr),
    .data_i  (axil_awaddr_i[ADDR_W-1:0]),
    .data_o  (aw_addr),
    .full_o  (aw_full)
  );

  iob_axil2iob_slot #(.DATA_W(WSLOT_W)) u_w_slot (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .arst_n_i(arst_n_i),
    .load_i  (w_hs),
    .clear_i (w_clr),
    .data_i  ({axil_wstrb_i, axil_wdata_i}),
    .data_o  (w_slot),
    .full_o  (w_full)
  );

  iob_axil2iob_slot #(.DATA_W(ADDR_W)) u_ar_slot (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .arst_n_i(arst_n_i),
    .load_i  (ar_hs),
    .clear_i (ar_clr),
    .data_i  (axil_araddr_i[ADDR_W-1:0]),
    .data_o  (ar_addr),
    .full_o  (ar_full)
  );

  // Pending requests include the ones being handshaken this cycle, so a
  // request accepted in cycle 0 is granted in cycle 0 and drives IOb in
  // cycle 1 from the registered state.
  assign write_pend = (aw_full | aw_hs) & (w_full | w_hs);
  assign read_pend  = ar_full | ar_hs;

`ifdef IOB_AXIL2IOB_RR_ARB_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_wr) begin
      last_grant_d = GRANT_WR;
    end else if (grant_rd) begin
      last_grant_d = GRANT_RD;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      last_grant_q <= GRANT_RD;
    end else if (cke_i) begin
      last_grant_q <= last_grant_d;
    end
  end

  // On a tie the type that did not win last time goes first.
  assign wr_wins_tie = (last_grant_q == GRANT_RD);
`else
  assign wr_wins_tie = 1'b1;
`endif

  assign grant_wr = (state_q == ST_IDLE) & write_pend & (~read_pend | wr_wins_tie);
  assign grant_rd = (state_q == ST_IDLE) & read_pend & ~grant_wr;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    aw_clr  = 1'b0;
    w_clr   = 1'b0;
    ar_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          state_d = ST_WR_REQ;
        end else if (grant_rd) begin
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (iob_ready_i) begin
          aw_clr  = 1'b1;
          w_clr   = 1'b1;
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axil_bready_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (iob_ready_i) begin
          ar_clr  = 1'b1;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (iob_rvalid_i) begin
          rdata_d = iob_rdata_i;
          state_d = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (axil_rready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // IOb request fields are only driven in the REQ states and are zero
  // otherwise. iob_rready_o is also high in WR_RESP so that a read response
  // the peripheral returns for a zero-strobe write is absorbed and dropped.
  always_comb begin
    iob_valid_o  = 1'b0;
    iob_addr_o   = '0;
    iob_wdata_o  = '0;
    iob_wstrb_o  = '0;
    iob_rready_o = 1'b0;
    case (state_q)
      ST_WR_REQ: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = aw_addr;
        iob_wdata_o = w_slot[AXIL_DATA_W-1:0];
        iob_wstrb_o = w_slot[WSLOT_W-1:AXIL_DATA_W];
      end
      ST_RD_REQ: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = ar_addr;
      end
      ST_WR_RESP, ST_RD_DATA: begin
        iob_rready_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign axil_awready_o = ~aw_full;
  assign axil_wready_o  = ~w_full;
  assign axil_arready_o = ~ar_full;
  assign axil_bvalid_o  = (state_q == ST_WR_RESP);
  assign axil_bresp_o   = RESP_OKAY;
  assign axil_rvalid_o  = (state_q == ST_RD_RESP);
  assign axil_rresp_o   = RESP_OKAY;
  assign axil_rdata_o   = rdata_q;

endmodule

// File: tb/tb_iob_axil2iob.sv
`timescale 1ns/1ps
// Scoreboard bench for iob_axil2iob: stimulus tasks push AXI-Lite requests
// into channel driver queues and expected IOb/AXI results into scoreboard
// queues; independent monitors pop and compare whenever the DUT presents
// a transfer.
module tb_iob_axil2iob;
  import iob_axil2iob_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          cke_i;
  logic          arst_n_i;
  logic [AW-1:0] axil_awaddr_i;
  logic          axil_awvalid_i;
  logic          axil_awready_o;
  logic [DW-1:0] axil_wdata_i;
  logic [3:0]    axil_wstrb_i;
  logic          axil_wvalid_i;
  logic          axil_wready_o;
  logic [1:0]    axil_bresp_o;
  logic          axil_bvalid_o;
  logic          axil_bready_i;
  logic [AW-1:0] axil_araddr_i;
  logic          axil_arvalid_i;
  logic          axil_arready_o;
  logic [DW-1:0] axil_rdata_o;
  logic [1:0]    axil_rresp_o;
  logic          axil_rvalid_o;
  logic          axil_rready_i;
  logic          iob_valid_o;
  logic [AW-1:0] iob_addr_o;
  logic [DW-1:0] iob_wdata_o;
  logic [3:0]    iob_wstrb_o;
  logic          iob_ready_i;
  logic          iob_rvalid_i;
  logic [DW-1:0] iob_rdata_i;
  logic          iob_rready_o;

  iob_axil2iob #(
    .AXIL_ADDR_W(AW), .AXIL_DATA_W(DW), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i),
    .axil_awaddr_i(axil_awaddr_i), .axil_awvalid_i(axil_awvalid_i), .axil_awready_o(axil_awready_o),
    .axil_wdata_i(axil_wdata_i), .axil_wstrb_i(axil_wstrb_i), .axil_wvalid_i(axil_wvalid_i),
    .axil_wready_o(axil_wready_o),
    .axil_bresp_o(axil_bresp_o), .axil_bvalid_o(axil_bvalid_o), .axil_bready_i(axil_bready_i),
    .axil_araddr_i(axil_araddr_i), .axil_arvalid_i(axil_arvalid_i), .axil_arready_o(axil_arready_o),
    .axil_rdata_o(axil_rdata_o), .axil_rresp_o(axil_rresp_o), .axil_rvalid_o(axil_rvalid_o),
    .axil_rready_i(axil_rready_i),
    .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i), .iob_rready_o(iob_rready_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  // Driver queues (what the AXI masters still have to present).
  logic [31:0] awQ[$];
  logic [35:0] wQ[$];
  logic [31:0] arQ[$];
  // Scoreboard queues (what the DUT must still produce).
  wr_t         expWrQ[$];
  logic [31:0] expRdQ[$];
  logic [31:0] expRQ[$];
  int          bOwed = 0;
  bit          isWrLog[$];
  int          rvalidCycles = 0;

  // Peripheral contents: preloaded words, otherwise a fixed address hash.
  logic [31:0] mem [logic [31:0]];

  int goPct      = 100;
  int bReadyPct  = 100;
  int rReadyPct  = 100;
  int ioReadyPct = 100;
  int rvDelayLo  = 0;
  int rvDelayHi  = 0;

  function automatic logic [31:0] periphRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: DUT produced a transfer, expected none", name);
  endtask

  // Reference model: a write is one IOb write with the same fields and one
  // OKAY B; a read is one IOb read of that address and one R carrying the
  // peripheral's word.
  task automatic applyStimulus(input bit isRead, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    wr_t w;
    if (isRead) begin
      arQ.push_back(addr);
      expRdQ.push_back(addr);
      expRQ.push_back(periphRead(addr));
    end else begin
      w.addr = addr; w.data = data; w.strb = strb;
      awQ.push_back(addr);
      wQ.push_back({strb, data});
      expWrQ.push_back(w);
    end
  endtask

  // AXI channel drivers: present the queue head, pop after the handshake.
  initial begin : awDrv
    bit hs = 0;
    axil_awvalid_i = 1'b0; axil_awaddr_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (hs) begin awQ.delete(0); axil_awvalid_i = 1'b0; end
      if (!axil_awvalid_i && awQ.size() > 0 && $urandom_range(0, 99) < goPct) begin
        axil_awvalid_i = 1'b1; axil_awaddr_i = awQ[0];
      end
      @(negedge clk_i); hs = axil_awvalid_i && axil_awready_o;
    end
  end

  initial begin : wDrv
    bit hs = 0;
    axil_wvalid_i = 1'b0; axil_wdata_i = '0; axil_wstrb_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (hs) begin wQ.delete(0); axil_wvalid_i = 1'b0; end
      if (!axil_wvalid_i && wQ.size() > 0 && $urandom_range(0, 99) < goPct) begin
        axil_wvalid_i = 1'b1; {axil_wstrb_i, axil_wdata_i} = wQ[0];
      end
      @(negedge clk_i); hs = axil_wvalid_i && axil_wready_o;
    end
  end

  initial begin : arDrv
    bit hs = 0;
    axil_arvalid_i = 1'b0; axil_araddr_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (hs) begin arQ.delete(0); axil_arvalid_i = 1'b0; end
      if (!axil_arvalid_i && arQ.size() > 0 && $urandom_range(0, 99) < goPct) begin
        axil_arvalid_i = 1'b1; axil_araddr_i = arQ[0];
      end
      @(negedge clk_i); hs = axil_arvalid_i && axil_arready_o;
    end
  end

  initial begin : readyDrv
    axil_bready_i = 1'b0; axil_rready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      axil_bready_i = ($urandom_range(0, 99) < bReadyPct);
      axil_rready_i = ($urandom_range(0, 99) < rReadyPct);
    end
  end

  // IOb peripheral: random ready; any request with wstrb==0 is a read to it
  // and gets an rvalid some cycles after the request was accepted.
  initial begin : periph
    bit hs, rdHs, rdPending;
    logic [31:0] hsAddr, rdNext;
    logic [3:0] hsStrb;
    int rdDelay;
    rdPending = 0; rdDelay = 0; rdNext = '0;
    iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      hs = iob_valid_o && iob_ready_i && arst_n_i;
      rdHs = iob_rvalid_i && iob_rready_o;
      hsAddr = iob_addr_o; hsStrb = iob_wstrb_o;
      @(posedge clk_i); #1;
      if (rdHs) begin iob_rvalid_i = 1'b0; iob_rdata_i = $urandom; end
      if (hs && hsStrb == 4'h0) begin
        rdPending = 1; rdDelay = $urandom_range(rvDelayLo, rvDelayHi); rdNext = periphRead(hsAddr);
      end
      if (rdPending) begin
        if (rdDelay == 0) begin
          iob_rvalid_i = 1'b1; iob_rdata_i = rdNext; rdPending = 0;
        end else begin
          rdDelay--;
        end
      end
      iob_ready_i = ($urandom_range(0, 99) < ioReadyPct);
    end
  end

  // IOb request monitor.
  initial begin : iobMon
    forever begin
      @(negedge clk_i);
      if (arst_n_i && iob_valid_o && iob_ready_i) begin
        if (iob_wstrb_o != 4'h0 || expRdQ.size() == 0) begin
          isWrLog.push_back(1'b1);
          if (expWrQ.size() == 0) reportUnexpected("iob_write");
          else begin
            checkOutput("iob_wr_addr", iob_addr_o, expWrQ[0].addr);
            checkOutput("iob_wr_data", iob_wdata_o, expWrQ[0].data);
            checkOutput("iob_wr_strb", 32'(iob_wstrb_o), 32'(expWrQ[0].strb));
            expWrQ.delete(0);
            bOwed++;
          end
        end else begin
          isWrLog.push_back(1'b0);
          checkOutput("iob_rd_addr", iob_addr_o, expRdQ[0]);
          expRdQ.delete(0);
        end
      end
    end
  end

  // B monitor: bresp checked every cycle bvalid is up.
  initial begin : bMon
    forever begin
      @(negedge clk_i);
      if (axil_bvalid_o) begin
        if (bOwed == 0) reportUnexpected("axil_b");
        else begin
          checkOutput("bresp", 32'(axil_bresp_o), 32'(RESP_OKAY));
          if (axil_bready_i) bOwed--;
        end
      end
    end
  end

  // R monitor: rdata checked every cycle rvalid is up, so it must stay
  // stable while the master stalls.
  initial begin : rMon
    forever begin
      @(negedge clk_i);
      if (axil_rvalid_o) begin
        rvalidCycles++;
        if (expRQ.size() == 0) reportUnexpected("axil_r");
        else begin
          checkOutput("rdata", axil_rdata_o, expRQ[0]);
          checkOutput("rresp", 32'(axil_rresp_o), 32'(RESP_OKAY));
          if (axil_rready_i) expRQ.delete(0);
        end
      end
    end
  end

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((awQ.size() + wQ.size() + arQ.size() + expWrQ.size() + expRdQ.size() +
            expRQ.size() + bOwed) != 0 || axil_bvalid_o || axil_rvalid_o) begin
      if (n >= budget) break;
      @(negedge clk_i);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout: waited %0d cycles, required < %0d", n, budget);
    end
    repeat (3) @(negedge clk_i);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_awready"}, 32'(axil_awready_o), 32'd1);
    checkOutput({tag, "_wready"},  32'(axil_wready_o),  32'd1);
    checkOutput({tag, "_arready"}, 32'(axil_arready_o), 32'd1);
    checkOutput({tag, "_bvalid"},  32'(axil_bvalid_o),  32'd0);
    checkOutput({tag, "_rvalid"},  32'(axil_rvalid_o),  32'd0);
    checkOutput({tag, "_iob_valid"},  32'(iob_valid_o),  32'd0);
    checkOutput({tag, "_iob_rready"}, 32'(iob_rready_o), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  initial begin : main
    int lat, s;
    bit seen;
    int rvBefore;
    cke_i = 1'b1;
    arst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    $display("[TB] reset state");
    checkResetOutputs("reset");
    checkOutput("reset_rdata", axil_rdata_o, 32'h0);
    checkOutput("reset_iob_addr", iob_addr_o, 32'h0);
    checkOutput("reset_iob_wdata", iob_wdata_o, 32'h0);
    checkOutput("reset_iob_wstrb", 32'(iob_wstrb_o), 32'h0);
    arst_n_i = 1'b1;
    @(negedge clk_i); #1;

    // Tie between reads and writes, first tie straight after reset.
    $display("[TB] contention");
    bReadyPct = 0;
    applyStimulus(1'b0, 32'h100, 32'h1111_0001, 4'hF);
    applyStimulus(1'b1, 32'h200, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h104, 32'h1111_0002, 4'h3);
    repeat (8) @(negedge clk_i);
    bReadyPct = 100;
    waitIdle(200);
    checkOutput("arb_count", 32'(isWrLog.size()), 32'd3);
    if (isWrLog.size() == 3) begin
`ifdef IOB_AXIL2IOB_RR_ARB_EN
      checkOutput("arb_first",  32'(isWrLog[0]), 32'd1);
      checkOutput("arb_second", 32'(isWrLog[1]), 32'd0);
      checkOutput("arb_third",  32'(isWrLog[2]), 32'd1);
`else
      checkOutput("arb_first",  32'(isWrLog[0]), 32'd1);
      checkOutput("arb_second", 32'(isWrLog[1]), 32'd1);
      checkOutput("arb_third",  32'(isWrLog[2]), 32'd0);
`endif
    end

    // Minimum write latency: AW+W in cycle 0, bvalid in cycle 2.
    $display("[TB] write latency");
    applyStimulus(1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk_i); #2;
    s = cyc; lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (axil_bvalid_o) begin lat = cyc - s; break; end
    end
    checkOutput("wr_latency", 32'(lat), 32'd2);
    waitIdle(100);

    // Minimum read latency plus rdata hold while rready is low.
    $display("[TB] read latency and hold");
    mem[32'h08] = 32'hCAFE_0001;
    rReadyPct = 0;
    applyStimulus(1'b1, 32'h08, 32'h0, 4'h0);
    @(posedge clk_i); #2;
    s = cyc; lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (axil_rvalid_o) begin lat = cyc - s; break; end
    end
    checkOutput("rd_latency", 32'(lat), 32'd3);
    repeat (4) @(negedge clk_i);
    rReadyPct = 100;
    waitIdle(100);

    // W arrives alone: no IOb traffic and W slot stays full until AW.
    $display("[TB] skewed write");
    ioReadyPct = 50;
    begin
      wr_t w;
      w.addr = 32'h24; w.data = 32'h1234_5678; w.strb = 4'hF;
      wQ.push_back({4'hF, 32'h1234_5678});
      expWrQ.push_back(w);
    end
    @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checkOutput("skew_wready", 32'(axil_wready_o), 32'd0);
      checkOutput("skew_iob_valid", 32'(iob_valid_o), 32'd0);
    end
    #1;
    awQ.push_back(32'h24);
    waitIdle(100);

    // B backpressure: second write is buffered but not issued.
    $display("[TB] b backpressure");
    ioReadyPct = 100;
    bReadyPct = 0;
    applyStimulus(1'b0, 32'h40, 32'hA5A5_0001, 4'hF);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      seen = axil_bvalid_o;
    end
    checkOutput("bp_bvalid_seen", 32'(seen), 32'd1);
    #1;
    applyStimulus(1'b0, 32'h44, 32'hA5A5_0002, 4'hC);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      checkOutput("bp_iob_valid", 32'(iob_valid_o), 32'd0);
      if (k >= 1) checkOutput("bp_awready", 32'(axil_awready_o), 32'd0);
    end
    bReadyPct = 100;
    waitIdle(100);

    // Zero-strobe write: looks like a read to IOb, completes as a write.
    $display("[TB] zero strobe write");
    rvBefore = rvalidCycles;
    applyStimulus(1'b0, 32'h30, 32'h0BAD_F00D, 4'h0);
    waitIdle(100);
    checkOutput("zstrb_no_rvalid", 32'(rvalidCycles - rvBefore), 32'd0);
    checkOutput("zstrb_periph_rvalid_dropped", 32'(iob_rvalid_i), 32'd0);

    // Randomised traffic.
    $display("[TB] random traffic");
    goPct = 50; bReadyPct = 70; rReadyPct = 70; ioReadyPct = 60;
    rvDelayLo = 0; rvDelayHi = 2;
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom & 32'h0000_FFFC, $urandom,
                    4'($urandom_range(1, 15)));
    end
    waitIdle(6000);

    // Reset while waiting for IOb read data.
    $display("[TB] reset in RD_DATA");
    goPct = 100; bReadyPct = 100; rReadyPct = 100; ioReadyPct = 100;
    rvDelayLo = 8; rvDelayHi = 8;
    applyStimulus(1'b1, 32'h80, 32'h0, 4'h0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      seen = iob_rready_o;
    end
    checkOutput("rst_reached_rd_data", 32'(seen), 32'd1);
    #1;
    arst_n_i = 1'b0;
    expRQ.delete();
    #1;
    checkResetOutputs("midrst");
    @(posedge clk_i); #3;
    arst_n_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      checkOutput("post_rst_rvalid", 32'(axil_rvalid_o), 32'd0);
      checkOutput("post_rst_iob_valid", 32'(iob_valid_o), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
